// File: rtl/pri_code_logger.sv
// ============================================================================
// Module   : pri_code_logger
// Brief    : Logs changes of a priority-encoder code into a timestamped FIFO,
//            with show-ahead pop and sticky overflow/illegal flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pri_code_logger #(
  parameter int         DEPTH     = 8,
  parameter logic [7:0] IDLE_CODE = 8'hF0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               code_in,
  input  logic                     sample_en,
  input  logic                     pop,
  input  logic                     clr_flags,
  output logic [15:0]              dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               last_code,
  output logic                     overflow,
  output logic                     illegal
);

  localparam int                AW       = $clog2(DEPTH);
  localparam int                CW       = AW + 1;
  localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);
  localparam logic [7:0]        MAX_REQ  = 8'h0E;

  logic [7:0]    stamp_q, stamp_d;
  logic [7:0]    last_code_q, last_code_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          illegal_q, illegal_d;
  logic [15:0]   mem_q [DEPTH];

  logic w_legal;
  logic w_change;
  logic w_empty;
  logic w_full;
  logic w_pop_ok;
  logic w_push_ok;

  always_comb begin
    w_legal   = (code_in <= MAX_REQ) || (code_in == IDLE_CODE);
    w_change  = sample_en && w_legal && (code_in != last_code_q);
    w_empty   = (count_q == '0);
    w_full    = (count_q == FULL_CNT);
    w_pop_ok  = pop && !w_empty;
    // A pop frees the slot that a push into a full FIFO needs.
    w_push_ok = w_change && (!w_full || w_pop_ok);
  end

  always_comb begin
    stamp_d     = stamp_q + 8'd1;
    last_code_d = last_code_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    illegal_d   = illegal_q;

    // Last code follows every detected change, even a dropped one,
    // so the same change is not re-detected next sample.
    if (w_change) begin
      last_code_d = code_in;
    end
    if (w_push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (w_pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({w_push_ok, w_pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (clr_flags) begin
      overflow_d = 1'b0;
      illegal_d  = 1'b0;
    end
    if (w_change && !w_push_ok) begin
      overflow_d = 1'b1;
    end
    if (sample_en && !w_legal) begin
      illegal_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stamp_q     <= 8'h00;
      last_code_q <= IDLE_CODE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      stamp_q     <= stamp_d;
      last_code_q <= last_code_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      illegal_q   <= illegal_d;
    end
  end

  // Storage needs no reset: an empty FIFO masks whatever it holds.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      mem_q[wr_ptr_q] <= {stamp_q, code_in};
    end
  end

  always_comb begin
    valid     = !w_empty;
    dout      = w_empty ? 16'h0000 : mem_q[rd_ptr_q];
    count     = count_q;
    last_code = last_code_q;
    overflow  = overflow_q;
    illegal   = illegal_q;
  end

endmodule

`default_nettype wire
